// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for one shared 3-bit seven-segment decoder across NUM_DIGITS digits.
// Optional per-slot dimming is enabled by defining SEG7_SCAN_DIM_EN (adds the duty input).
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [3:0]              duty,
`endif
  input  logic                    en,
  input  logic                    load_valid,
  input  logic [3*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [2:0]              dec_code,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    blank,
  output logic                    frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 3 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
`ifdef SEG7_SCAN_DIM_EN
  localparam int STEP = (SCAN_DIV - BLANK_CYC) / 16;
`endif

  // ST_IDLE is the registered image of en=0; it keeps en off every output path.
  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   active_q, active_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic            load_fire;
  logic            frame_wrap;
  logic            commit;
  logic            slot_on;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]      duty_q;
  logic [31:0]     on_end;
`endif

  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    load_fire  = load_valid && !pending_q;
    frame_wrap = (state_q == ST_SCAN) && en && (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_SCAN;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Commit reads shadow_q before a same-edge capture overwrites it, so a
    // boundary collision shows old data now and the new data next frame.
    commit = pending_q && (!en || frame_wrap);
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load_fire) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
  end

  // NOTE: the display buffers are reset along with the counters so a reset discards any pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

`ifdef SEG7_SCAN_DIM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (cnt_d == '0) begin
      duty_q <= duty;
    end
  end

  assign on_end = 32'(BLANK_CYC) + (32'(duty_q) + 32'd1) * 32'(STEP);
`endif

  always_comb begin
    slot_on = (state_q == ST_SCAN) && (32'(cnt_q) >= 32'(BLANK_CYC));
`ifdef SEG7_SCAN_DIM_EN
    slot_on = slot_on && (32'(cnt_q) < on_end);
`endif
    digit_en = slot_on ? (NUM_DIGITS'(1) << idx_q) : '0;
  end

  assign blank       = ~|digit_en;
  assign dec_code    = active_q[3*idx_q +: 3];
  assign frame_start = (state_q == ST_SCAN) && (cnt_q == '0) && (idx_q == '0);
  assign load_ready  = ~pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues the expected display state for each
// cycle and a negedge monitor pops and compares it against the DUT outputs.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          load_valid;
  logic [11:0]   load_data;
  logic          load_ready;
  logic [2:0]    dec_code;
  logic [ND-1:0] digit_en;
  logic          blank;
  logic          frame_start;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .dec_code   (dec_code),
    .digit_en   (digit_en),
    .blank      (blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] de;
    logic       fs;
    logic [2:0] code;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Bench view of the display: scanning flag, cycles since scan restart, committed data, ready.
  bit          scanning = 0;
  int          t = 0;
  logic [11:0] exp_active = '0;
  logic        exp_rdy = 1'b1;

  localparam logic [11:0] DAT_A = 12'b101_100_011_010;
  localparam logic [11:0] DAT_B = 12'b110_111_001_000;
  localparam logic [11:0] DAT_C = 12'b011_001_101_110;
  localparam logic [11:0] DAT_D = 12'b000_101_010_111;
  localparam logic [11:0] DAT_E = 12'b010_010_010_001;
  localparam logic [11:0] DAT_F = 12'b111_111_111_111;

  task automatic check(input string name, input int tt, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, tt, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("digit_en",    e.t, 32'(digit_en),    32'(e.de));
      check("blank",       e.t, 32'(blank),       32'(e.de == 4'd0));
      check("frame_start", e.t, 32'(frame_start), 32'(e.fs));
      check("dec_code",    e.t, 32'(dec_code),    32'(e.code));
      check("load_ready",  e.t, 32'(load_ready),  32'(e.rdy));
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc();
    exp_t e;
    int   slot;
    slot   = (t / SD) % ND;
    e.t    = scanning ? t : -1;
    e.de   = (scanning && (t % SD) >= BC) ? 4'(1 << slot) : 4'd0;
    e.fs   = scanning && (t % (SD * ND) == 0);
    e.code = scanning ? exp_active[3*slot +: 3] : exp_active[2:0];
    e.rdy  = exp_rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst_n)        scanning = 0;
    else if (!en)      scanning = 0;
    else if (scanning) t++;
    else begin
      scanning = 1;
      t = 0;
    end
  endtask

  task automatic run_until(input int target);
    while (scanning && t < target) cyc();
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Scan pattern and first load during digit 1's slot.
    en = 1'b1;
    cyc();
    run_until(20);
    load_valid = 1'b1;
    load_data  = DAT_A;
    cyc();
    load_valid = 1'b0;
    exp_rdy    = 1'b0;
    run_until(63);
    cyc();
    exp_active = DAT_A;
    exp_rdy    = 1'b1;

    // Back-pressure: C is held while B is pending and accepted only after B commits.
    run_until(84);
    load_valid = 1'b1;
    load_data  = DAT_B;
    cyc();
    load_valid = 1'b0;
    exp_rdy    = 1'b0;
    run_until(100);
    load_valid = 1'b1;
    load_data  = DAT_C;
    run_until(127);
    cyc();
    exp_active = DAT_B;
    exp_rdy    = 1'b1;
    cyc();
    load_valid = 1'b0;
    exp_rdy    = 1'b0;
    run_until(191);
    cyc();
    exp_active = DAT_C;
    exp_rdy    = 1'b1;

    // Boundary collision: handshake exactly on the frame-wrap edge.
    run_until(255);
    load_valid = 1'b1;
    load_data  = DAT_D;
    cyc();
    load_valid = 1'b0;
    exp_rdy    = 1'b0;
    run_until(319);
    cyc();
    exp_active = DAT_D;
    exp_rdy    = 1'b1;

    // en dropped mid-slot for 5 edges, with a load committing while disabled.
    run_until(342);
    en = 1'b0;
    cyc();
    load_valid = 1'b1;
    load_data  = DAT_E;
    cyc();
    load_valid = 1'b0;
    exp_rdy    = 1'b0;
    cyc();
    exp_active = DAT_E;
    exp_rdy    = 1'b1;
    cyc();
    cyc();
    en = 1'b1;
    cyc();
    run_until(70);

    // Mid-frame reset with a pending load that must be discarded.
    load_valid = 1'b1;
    load_data  = DAT_F;
    cyc();
    load_valid = 1'b0;
    exp_rdy    = 1'b0;
    run_until(90);
    rst_n      = 1'b0;
    scanning   = 0;
    exp_active = '0;
    exp_rdy    = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    run_until(70);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
